// File: rtl/demo_sequencer.sv
// Frame-rate scene scheduler for the VGA demo: selects the active effect, counts frames,
// runs fade-out/fade-in transitions and a reload handshake with the renderer at each scene change.
module demo_sequencer #(
    parameter int NUM_SCENES  = 4,
    parameter int SCENE_LEN   = 512,
    parameter int ACK_TIMEOUT = 1024,
    localparam int SCENE_W    = (NUM_SCENES > 1) ? $clog2(NUM_SCENES) : 1
) (
    input  logic               clk48,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               pause_n,
    input  logic               skip,
    input  logic               scene_ack,
    output logic [SCENE_W-1:0] scene,
    output logic [9:0]         scene_frame,
    output logic [15:0]        global_frame,
    output logic [2:0]         fade,
    output logic               scene_req,
    output logic               in_transition,
    output logic               ack_err
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FADE_OUT,
        ST_SWITCH,
        ST_FADE_IN
    } state_t;

    // Fade-out starts 8 frames before the end so the 7 dim steps plus the switch tick fill the scene.
    localparam logic [9:0]  RUN_END    = 10'(SCENE_LEN - 8);
    localparam logic [15:0] TMO_LAST   = 16'(ACK_TIMEOUT - 1);
    localparam logic [SCENE_W-1:0] LAST_SCENE = SCENE_W'(NUM_SCENES - 1);

    state_t               state_q, state_d;
    logic [SCENE_W-1:0]   scene_q, scene_d;
    logic [9:0]           frame_q, frame_d;
    logic [15:0]          global_q, global_d;
    logic [2:0]           fade_q, fade_d;
    logic                 req_q, req_d;
    logic                 trans_q, trans_d;
    logic                 err_q, err_d;
    logic [15:0]          tmo_q, tmo_d;
    logic                 active;

    function automatic logic [9:0] sat_inc(input logic [9:0] x);
        return (x == 10'd1023) ? x : x + 10'd1;
    endfunction

    function automatic logic [SCENE_W-1:0] next_scene(input logic [SCENE_W-1:0] s);
        return (s == LAST_SCENE) ? '0 : s + SCENE_W'(1);
    endfunction

    assign active = frame_tick & pause_n;

    always_comb begin
        state_d  = state_q;
        scene_d  = scene_q;
        frame_d  = frame_q;
        global_d = global_q + {15'd0, active};
        fade_d   = fade_q;
        req_d    = req_q;
        err_d    = err_q;
        tmo_d    = '0;

        case (state_q)
            ST_RUN: begin
                if (active) begin
                    frame_d = sat_inc(frame_q);
                    if (frame_d >= RUN_END) begin
                        state_d = ST_FADE_OUT;
                    end
                end
                if (skip) begin
                    state_d = ST_FADE_OUT;
                end
            end
            ST_FADE_OUT: begin
                if (active) begin
                    if (fade_q != 3'd7) begin
                        fade_d  = fade_q + 3'd1;
                        frame_d = sat_inc(frame_q);
                    end else begin
                        state_d = ST_SWITCH;
                        scene_d = next_scene(scene_q);
                        frame_d = '0;
                        req_d   = 1'b1;
                    end
                end
            end
            ST_SWITCH: begin
                // Handshake ignores pause_n; the timeout counter only runs while here.
                tmo_d = tmo_q + 16'd1;
                if (scene_ack || tmo_q == TMO_LAST) begin
                    state_d = ST_FADE_IN;
                    req_d   = 1'b0;
                    fade_d  = 3'd7;
                    if (!scene_ack) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FADE_IN: begin
                if (active && fade_q != 3'd0) begin
                    fade_d  = fade_q - 3'd1;
                    frame_d = sat_inc(frame_q);
                    if (fade_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_FADE_IN;
        endcase

        trans_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FADE_IN;
            scene_q  <= '0;
            frame_q  <= '0;
            global_q <= '0;
            fade_q   <= 3'd7;
            req_q    <= 1'b0;
            trans_q  <= 1'b1;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            scene_q  <= scene_d;
            frame_q  <= frame_d;
            global_q <= global_d;
            fade_q   <= fade_d;
            req_q    <= req_d;
            trans_q  <= trans_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign scene         = scene_q;
    assign scene_frame   = frame_q;
    assign global_frame  = global_q;
    assign fade          = fade_q;
    assign scene_req     = req_q;
    assign in_transition = trans_q;
    assign ack_err       = err_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// Scoreboard bench for demo_sequencer: expected output snapshots are queued per stimulus step
// and compared against the DUT one cycle later.
module tb_demo_sequencer;

    logic        clk48;
    logic        rst;
    logic        frame_tick;
    logic        pause_n;
    logic        skip;
    logic        scene_ack;
    logic [1:0]  scene;
    logic [9:0]  scene_frame;
    logic [15:0] global_frame;
    logic [2:0]  fade;
    logic        scene_req;
    logic        in_transition;
    logic        ack_err;

    typedef struct packed {
        logic [1:0]  sc;
        logic [9:0]  fr;
        logic [15:0] gl;
        logic [2:0]  fd;
        logic        rq;
        logic        tr;
        logic        er;
    } obs_t;

    obs_t exp_q[$];
    obs_t got, want;
    int   total = 0;
    int   bad   = 0;

    demo_sequencer #(
        .NUM_SCENES (4),
        .SCENE_LEN  (32),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk48        (clk48),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .pause_n      (pause_n),
        .skip         (skip),
        .scene_ack    (scene_ack),
        .scene        (scene),
        .scene_frame  (scene_frame),
        .global_frame (global_frame),
        .fade         (fade),
        .scene_req    (scene_req),
        .in_transition(in_transition),
        .ack_err      (ack_err)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    function automatic obs_t obs();
        obs_t o;
        o.sc = scene; o.fr = scene_frame; o.gl = global_frame; o.fd = fade;
        o.rq = scene_req; o.tr = in_transition; o.er = ack_err;
        return o;
    endfunction

    function automatic obs_t mk(input logic [1:0] sc, input logic [9:0] fr, input logic [15:0] gl,
                                input logic [2:0] fd, input logic rq, input logic tr, input logic er);
        obs_t o;
        o.sc = sc; o.fr = fr; o.gl = gl; o.fd = fd; o.rq = rq; o.tr = tr; o.er = er;
        return o;
    endfunction

    // One clock: apply inputs at a falling edge, return at the next falling edge.
    task automatic drive(input logic ft, input logic ak, input logic sk);
        frame_tick = ft; scene_ack = ak; skip = sk;
        @(negedge clk48);
        frame_tick = 1'b0; scene_ack = 1'b0; skip = 1'b0;
    endtask

    task automatic test_reset();
        exp_q.push_back(mk(2'd0, 10'd0, 16'd0, 3'd7, 1'b0, 1'b1, 1'b0));
        frame_tick = 1'b1;
        @(negedge clk48);
        @(negedge clk48);
        frame_tick = 1'b0;
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL reset_state: got %h want %h", got, want);
        end
        rst = 1'b0;
    endtask

    task automatic fade_in(input logic [1:0] sc, input int g0, input logic er, input string nm);
        for (int k = 1; k <= 7; k++) begin
            exp_q.push_back(mk(sc, 10'(k), 16'(g0 + k), 3'(7 - k), 1'b0, k < 7, er));
            drive(1'b1, 1'b0, 1'b0);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL %s tick %0d: got %h want %h", nm, k, got, want);
            end
        end
    endtask

    // From RUN at scene_frame=7 to the tick that enters SWITCH.
    task automatic run_to_switch(input logic [1:0] sc, input int g0, input logic er, input string nm);
        logic [1:0] nsc;
        nsc = sc + 2'd1;
        for (int t = 8; t <= 32; t++) begin
            if (t == 32)
                exp_q.push_back(mk(nsc, 10'd0, 16'(g0 + 25), 3'd7, 1'b1, 1'b1, er));
            else
                exp_q.push_back(mk(sc, 10'(t), 16'(g0 + t - 7), (t <= 24) ? 3'd0 : 3'(t - 24),
                                   1'b0, t >= 24, er));
            drive(1'b1, 1'b0, 1'b0);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL %s frame %0d: got %h want %h", nm, t, got, want);
            end
        end
    endtask

    task automatic test_power_up();
        fade_in(2'd0, 0, 1'b0, "power_up_fade");
    endtask

    task automatic test_full_scene();
        run_to_switch(2'd0, 7, 1'b0, "full_scene");
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(mk(2'd1, 10'd0, 16'd32, 3'd7, 1'b1, 1'b1, 1'b0));
            drive(1'b0, 1'b0, 1'b0);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL req_hold cycle %0d: got %h want %h", c, got, want);
            end
        end
        exp_q.push_back(mk(2'd1, 10'd0, 16'd32, 3'd7, 1'b0, 1'b1, 1'b0));
        drive(1'b0, 1'b1, 1'b0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL ack_release: got %h want %h", got, want);
        end
        fade_in(2'd1, 32, 1'b0, "scene1_fade_in");
    endtask

    task automatic test_pause();
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(mk(2'd1, 10'(7 + k), 16'(39 + k), 3'd0, 1'b0, 1'b0, 1'b0));
            drive(1'b1, 1'b0, 1'b0);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL pre_pause %0d: got %h want %h", k, got, want);
            end
        end
        pause_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(mk(2'd1, 10'd10, 16'd42, 3'd0, 1'b0, 1'b0, 1'b0));
            drive(1'b1, 1'b0, 1'b0);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL paused_tick %0d: got %h want %h", k, got, want);
            end
        end
        pause_n = 1'b1;
        exp_q.push_back(mk(2'd1, 10'd11, 16'd43, 3'd0, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 1'b0, 1'b0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL resume: got %h want %h", got, want);
        end
    endtask

    task automatic test_skip();
        pause_n = 1'b0;
        exp_q.push_back(mk(2'd1, 10'd11, 16'd43, 3'd0, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 1'b0, 1'b1);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL skip_paused: got %h want %h", got, want);
        end
        pause_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8)
                exp_q.push_back(mk(2'd2, 10'd0, 16'd51, 3'd7, 1'b1, 1'b1, 1'b0));
            else
                exp_q.push_back(mk(2'd1, 10'(11 + k), 16'(43 + k), 3'(k), 1'b0, 1'b1, 1'b0));
            drive(1'b1, 1'b0, 1'b0);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL skip_fade_out %0d: got %h want %h", k, got, want);
            end
        end
        exp_q.push_back(mk(2'd2, 10'd0, 16'd52, 3'd7, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 1'b1, 1'b0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL ack_with_tick: got %h want %h", got, want);
        end
        exp_q.push_back(mk(2'd2, 10'd0, 16'd52, 3'd7, 1'b0, 1'b1, 1'b0));
        drive(1'b0, 1'b0, 1'b1);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL skip_in_fade_in: got %h want %h", got, want);
        end
        fade_in(2'd2, 52, 1'b0, "scene2_fade_in");
    endtask

    task automatic test_ack_timeout();
        run_to_switch(2'd2, 59, 1'b0, "to_timeout");
        for (int c = 1; c <= 16; c++) begin
            if (c == 16)
                exp_q.push_back(mk(2'd3, 10'd0, 16'd84, 3'd7, 1'b0, 1'b1, 1'b1));
            else
                exp_q.push_back(mk(2'd3, 10'd0, 16'd84, 3'd7, 1'b1, 1'b1, 1'b0));
            drive(1'b0, 1'b0, 1'b0);
            got = obs(); want = exp_q.pop_front(); total++;
            if (got !== want) begin
                bad++; $display("FAIL timeout_cycle %0d: got %h want %h", c, got, want);
            end
        end
        exp_q.push_back(mk(2'd3, 10'd0, 16'd84, 3'd7, 1'b0, 1'b1, 1'b1));
        drive(1'b0, 1'b1, 1'b0);
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL late_ack_ignored: got %h want %h", got, want);
        end
        fade_in(2'd3, 84, 1'b1, "after_timeout_fade_in");
    endtask

    task automatic test_wrap_reset();
        run_to_switch(2'd3, 91, 1'b1, "scene_wrap");
        exp_q.push_back(mk(2'd0, 10'd0, 16'd0, 3'd7, 1'b0, 1'b1, 1'b0));
        rst = 1'b1;
        #1;
        got = obs(); want = exp_q.pop_front(); total++;
        if (got !== want) begin
            bad++; $display("FAIL async_reset_mid_req: got %h want %h", got, want);
        end
        @(negedge clk48);
        rst = 1'b0;
    endtask

    task automatic test_global_wrap();
        exp_q.push_back(mk(2'd0, 10'd0, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(2'd0, 10'd0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0));
        frame_tick = 1'b1;
        repeat (65535) @(negedge clk48);
        want = exp_q.pop_front(); total++;
        if (global_frame !== want.gl) begin
            bad++; $display("FAIL global_max: got %h want %h", global_frame, want.gl);
        end
        @(negedge clk48);
        frame_tick = 1'b0;
        want = exp_q.pop_front(); total++;
        if (global_frame !== want.gl) begin
            bad++; $display("FAIL global_wrap: got %h want %h", global_frame, want.gl);
        end
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        pause_n    = 1'b1;
        skip       = 1'b0;
        scene_ack  = 1'b0;
        test_reset();
        test_power_up();
        test_full_scene();
        test_pause();
        test_skip();
        test_ack_timeout();
        test_wrap_reset();
        test_global_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
